// File: rtl/arb_req_agent.sv
// Requester-side agent for a 4-input fixed-priority grant arbiter.
// Accepts burst requests from four clients, drives the arbiter request lines,
// qualifies the arbiter's registered encoded grant and turns it into a locked
// one-hot ownership window of (len + 1) cycles. While a burst owns the bus,
// every other request line is masked so the burst cannot be preempted.
//
// Ports:
//   arb_clk, arb_rst          clock, asynchronous active-high reset
//   cli_valid[3:0]            per-client burst request
//   cli_len[4*LEN_W-1:0]      per-client burst length, field i at [i*LEN_W +: LEN_W]
//   arb_gnt[1:0]              encoded grant from the arbiter (registered there)
//   arb_req0..arb_req3        request lines to the arbiter
//   cli_accept[3:0]           one-cycle pulse when a request is latched
//   cli_gnt[3:0]              one-hot ownership, high for the whole burst
//   cli_done[3:0]             one-cycle pulse in the final ownership cycle
//   cli_starve[3:0]           sticky: client waited more than WAIT_MAX cycles
//   arb_err                   sticky: grant mismatch during a burst
module arb_req_agent #(
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic               arb_clk,
    input  logic               arb_rst,
    input  logic [3:0]         cli_valid,
    input  logic [4*LEN_W-1:0] cli_len,
    input  logic [1:0]         arb_gnt,
    output logic               arb_req0,
    output logic               arb_req1,
    output logic               arb_req2,
    output logic               arb_req3,
    output logic [3:0]         cli_accept,
    output logic [3:0]         cli_gnt,
    output logic [3:0]         cli_done,
    output logic [3:0]         cli_starve,
    output logic               arb_err
);

    // Wait counter saturates at WAIT_MAX + 1, one past the starvation limit.
    localparam int unsigned    WaitW   = $clog2(WAIT_MAX + 2);
    localparam logic [WaitW-1:0] WaitLim = WaitW'(WAIT_MAX);
    localparam logic [WaitW-1:0] WaitSat = WaitW'(WAIT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StReq, StOwn} state_e;

    state_e             state_q [4];
    state_e             state_d [4];
    logic [LEN_W-1:0]   len_q   [4];
    logic [LEN_W-1:0]   len_d   [4];
    logic [WaitW-1:0]   wait_q  [4];
    logic [WaitW-1:0]   wait_d  [4];
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         owner_q, owner_d;
    logic               first_q, first_d;
    logic [3:0]         req_q, req_d;
    logic [3:0]         req_prev_q;
    logic [3:0]         accept_q, accept_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [3:0]         done_q, done_d;
    logic [3:0]         starve_q, starve_d;
    logic               err_q, err_d;

    logic               own_any_q, own_any_d;
    logic               gnt_vld;

    always_comb begin
        own_any_q = 1'b0;
        own_any_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
            wait_d[i]  = wait_q[i];
        end
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        first_d  = first_q;
        accept_d = '0;
        starve_d = starve_q;
        err_d    = err_q;
        req_d    = '0;
        gnt_d    = '0;
        done_d   = '0;

        // The arbiter holds its last grant when idle, so a grant only means
        // something if some request was presented to it one cycle earlier.
        gnt_vld = |req_prev_q;

        for (int i = 0; i < 4; i++) begin
            if (state_q[i] == StOwn) begin
                own_any_q = 1'b1;
            end
        end

        if (own_any_q) begin
            first_d = 1'b0;
            // First OWN cycle still shows the grant that caused entry.
            if (!first_q && (arb_gnt != owner_q)) begin
                err_d = 1'b1;
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            unique case (state_q[i])
                StIdle: begin
                    if (cli_valid[i] && !own_any_q) begin
                        state_d[i]  = StReq;
                        len_d[i]    = cli_len[i*LEN_W +: LEN_W];
                        accept_d[i] = 1'b1;
                    end
                end
                StReq: begin
                    if (!own_any_q && gnt_vld && (arb_gnt == 2'(i)) && req_prev_q[i]) begin
                        state_d[i]  = StOwn;
                        cnt_d       = len_q[i];
                        owner_d     = 2'(i);
                        first_d     = 1'b1;
                        starve_d[i] = 1'b0;
                        wait_d[i]   = '0;
                    end else begin
                        if (wait_q[i] != WaitSat) begin
                            wait_d[i] = wait_q[i] + 1'b1;
                        end
                        // New count exceeds WAIT_MAX.
                        if (wait_q[i] >= WaitLim) begin
                            starve_d[i] = 1'b1;
                        end
                    end
                end
                StOwn: begin
                    if (cnt_q == '0) begin
                        state_d[i] = StIdle;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end

        for (int i = 0; i < 4; i++) begin
            if (state_d[i] == StOwn) begin
                own_any_d = 1'b1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            gnt_d[i]  = (state_d[i] == StOwn);
            done_d[i] = (state_d[i] == StOwn) && (cnt_d == '0);
            req_d[i]  = (state_d[i] == StOwn) || ((state_d[i] == StReq) && !own_any_d);
        end
    end

    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StIdle;
                len_q[i]   <= '0;
                wait_q[i]  <= '0;
            end
            cnt_q      <= '0;
            owner_q    <= '0;
            first_q    <= 1'b0;
            req_q      <= '0;
            req_prev_q <= '0;
            accept_q   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
                wait_q[i]  <= wait_d[i];
            end
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            first_q    <= first_d;
            req_q      <= req_d;
            req_prev_q <= req_q;
            accept_q   <= accept_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
        end
    end

    assign arb_req0   = req_q[0];
    assign arb_req1   = req_q[1];
    assign arb_req2   = req_q[2];
    assign arb_req3   = req_q[3];
    assign cli_accept = accept_q;
    assign cli_gnt    = gnt_q;
    assign cli_done   = done_q;
    assign cli_starve = starve_q;
    assign arb_err    = err_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent. A behavioural fixed-priority arbiter
// (req1 > req3 > req2 > req0, registered grant, holds when idle) closes the
// loop; its output can be overridden to inject stale or wrong grants.
module tb_arb_req_agent;

    logic        arb_clk;
    logic        arb_rst;
    logic [3:0]  cli_valid;
    logic [15:0] cli_len;
    logic [1:0]  arb_gnt;
    logic        arb_req0, arb_req1, arb_req2, arb_req3;
    logic [3:0]  cli_accept, cli_gnt, cli_done, cli_starve;
    logic        arb_err;

    logic [3:0]  req_bus;
    logic [1:0]  model_gnt;
    logic        force_en;
    logic [1:0]  force_val;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] t2_gnt [14];
    logic [3:0] t2_req [14];

    arb_req_agent #(
        .LEN_W    (4),
        .WAIT_MAX (4)
    ) u_dut (
        .arb_clk    (arb_clk),
        .arb_rst    (arb_rst),
        .cli_valid  (cli_valid),
        .cli_len    (cli_len),
        .arb_gnt    (arb_gnt),
        .arb_req0   (arb_req0),
        .arb_req1   (arb_req1),
        .arb_req2   (arb_req2),
        .arb_req3   (arb_req3),
        .cli_accept (cli_accept),
        .cli_gnt    (cli_gnt),
        .cli_done   (cli_done),
        .cli_starve (cli_starve),
        .arb_err    (arb_err)
    );

    assign req_bus = {arb_req3, arb_req2, arb_req1, arb_req0};

    initial arb_clk = 1'b0;
    always #5 arb_clk = ~arb_clk;

    always @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            model_gnt <= 2'd0;
        end else if (arb_req1) begin
            model_gnt <= 2'd1;
        end else if (arb_req3) begin
            model_gnt <= 2'd3;
        end else if (arb_req2) begin
            model_gnt <= 2'd2;
        end else if (arb_req0) begin
            model_gnt <= 2'd0;
        end
    end

    assign arb_gnt = force_en ? force_val : model_gnt;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_req"}, req_bus, 4'h0);
        check_eq({tag, "_acc"}, cli_accept, 4'h0);
        check_eq({tag, "_gnt"}, cli_gnt, 4'h0);
        check_eq({tag, "_done"}, cli_done, 4'h0);
        check_eq({tag, "_starve"}, cli_starve, 4'h0);
        check_eq({tag, "_err"}, 4'(arb_err), 4'h0);
    endtask

    task automatic set_len(input int idx, input logic [3:0] v);
        cli_len[idx*4 +: 4] = v;
    endtask

    initial begin
        arb_rst   = 1'b1;
        cli_valid = '0;
        cli_len   = '0;
        force_en  = 1'b0;
        force_val = 2'd0;
        t2_gnt = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h8,
                   4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h1, 4'h0};
        t2_req = '{4'h0, 4'hf, 4'hf, 4'h2, 4'hd, 4'hd, 4'h8,
                   4'h5, 4'h5, 4'h4, 4'h1, 4'h1, 4'h1, 4'h0};
        #1;
        check_zero("rst");
        repeat (2) @(posedge arb_clk);
        #1;
        arb_rst = 1'b0;
        repeat (3) tick();
        check_zero("idle");

        // Single client 2, len 3.
        set_len(2, 4'd3);
        cli_valid = 4'b0100;
        tick();
        check_eq("t1_acc_c1", cli_accept, 4'b0100);
        check_eq("t1_req_c1", req_bus, 4'b0100);
        cli_valid = '0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check_eq($sformatf("t1_gnt_c%0d", c), cli_gnt, (c >= 3 && c <= 6) ? 4'b0100 : 4'b0);
            check_eq($sformatf("t1_done_c%0d", c), cli_done, (c == 6) ? 4'b0100 : 4'b0);
            check_eq($sformatf("t1_req_c%0d", c), req_bus, (c <= 6) ? 4'b0100 : 4'b0);
            check_eq($sformatf("t1_acc_c%0d", c), cli_accept, 4'b0);
        end
        repeat (2) tick();

        // All four at once, len 0: ownership 1, 3, 2, 0.
        cli_len   = '0;
        cli_valid = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) begin
                check_eq("t2_acc_c1", cli_accept, 4'b1111);
                cli_valid = '0;
            end
            check_eq($sformatf("t2_gnt_c%0d", c), cli_gnt, t2_gnt[c]);
            check_eq($sformatf("t2_done_c%0d", c), cli_done, t2_gnt[c]);
            check_eq($sformatf("t2_req_c%0d", c), req_bus, t2_req[c]);
            check_eq($sformatf("t2_onehot_c%0d", c), 4'($countones(cli_gnt) <= 1), 4'h1);
        end
        check_eq("t2_starve_end", cli_starve, 4'h0);
        repeat (2) tick();

        // Preemption attempt: client 0 owns len 7, client 1 requests mid-burst.
        set_len(0, 4'd7);
        set_len(1, 4'd0);
        cli_valid = 4'b0001;
        tick();
        check_eq("t3_acc_c1", cli_accept, 4'b0001);
        check_eq("t3_req_c1", req_bus, 4'b0001);
        cli_valid = '0;
        for (int c = 2; c <= 16; c++) begin
            tick();
            check_eq($sformatf("t3_gnt0_c%0d", c), 4'(cli_gnt[0]), 4'(c >= 3 && c <= 10));
            check_eq($sformatf("t3_done0_c%0d", c), 4'(cli_done[0]), 4'(c == 10));
            check_eq($sformatf("t3_req0_c%0d", c), 4'(arb_req0), 4'(c <= 10));
            check_eq($sformatf("t3_req1_c%0d", c), 4'(arb_req1), 4'(c >= 12 && c <= 14));
            check_eq($sformatf("t3_acc1_c%0d", c), 4'(cli_accept[1]), 4'(c == 12));
            check_eq($sformatf("t3_gnt1_c%0d", c), 4'(cli_gnt[1]), 4'(c == 14));
            if (c == 4) cli_valid = 4'b0010;
            if (c == 12) cli_valid = '0;
        end
        check_eq("t3_err", 4'(arb_err), 4'h0);

        // Stale grant 2'b11 with nothing requesting.
        force_val = 2'b11;
        force_en  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_eq($sformatf("t4_gnt_c%0d", c), cli_gnt, 4'h0);
            check_eq($sformatf("t4_req_c%0d", c), req_bus, 4'h0);
            check_eq($sformatf("t4_acc_c%0d", c), cli_accept, 4'h0);
        end
        force_en = 1'b0;
        repeat (2) tick();

        // Starvation: client 0 waits behind client 1 (len 3, valid held).
        set_len(0, 4'd0);
        set_len(1, 4'd3);
        cli_valid = 4'b0011;
        for (int c = 1; c <= 16; c++) begin
            logic [3:0] e_req;
            tick();
            if (c <= 2 || c == 8)      e_req = 4'b0011;
            else if (c <= 6)           e_req = 4'b0010;
            else if (c == 7 || c == 9) e_req = 4'b0001;
            else if (c <= 15)          e_req = 4'b0010;
            else                       e_req = 4'b0000;
            check_eq($sformatf("t5_starve_c%0d", c), cli_starve, 4'(c >= 6 && c <= 8));
            check_eq($sformatf("t5_gnt0_c%0d", c), 4'(cli_gnt[0]), 4'(c == 9));
            check_eq($sformatf("t5_gnt1_c%0d", c), 4'(cli_gnt[1]),
                     4'((c >= 3 && c <= 6) || (c >= 12 && c <= 15)));
            check_eq($sformatf("t5_acc1_c%0d", c), 4'(cli_accept[1]), 4'(c == 1 || c == 8));
            check_eq($sformatf("t5_req_c%0d", c), req_bus, e_req);
            if (c == 1) cli_valid = 4'b0010;
            if (c == 8) cli_valid = '0;
        end
        repeat (2) tick();

        // Wrong grant during client 3's burst: error sets, burst completes.
        set_len(3, 4'd3);
        cli_valid = 4'b1000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_eq($sformatf("t6_gnt_c%0d", c), cli_gnt, (c >= 3 && c <= 6) ? 4'b1000 : 4'b0);
            check_eq($sformatf("t6_done_c%0d", c), cli_done, (c == 6) ? 4'b1000 : 4'b0);
            check_eq($sformatf("t6_err_c%0d", c), 4'(arb_err), 4'(c >= 5));
            if (c == 1) cli_valid = '0;
            if (c == 4) begin
                force_val = 2'b10;
                force_en  = 1'b1;
            end
            if (c == 5) force_en = 1'b0;
        end

        // Reset in the middle of client 2's burst.
        set_len(2, 4'd7);
        cli_valid = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) cli_valid = '0;
        end
        check_eq("t7_gnt_pre", cli_gnt, 4'b0100);
        check_eq("t7_err_pre", 4'(arb_err), 4'h1);
        #2;
        arb_rst = 1'b1;
        #1;
        check_zero("t7_async");
        repeat (2) tick();
        check_zero("t7_held");
        arb_rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_eq($sformatf("t7_done_c%0d", c), cli_done, 4'h0);
            check_eq($sformatf("t7_gnt_c%0d", c), cli_gnt, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
